// File: rtl/disp_msg_src.sv
// Debounced BTNC press streams the "HI" glyph message to the display sink over valid/ready.
// Define DISP_MSG_REPEAT_EN to loop the message until a second press stops it.
module disp_msg_src #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MSG_LEN         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNC,
    input  logic       ready,
    output logic       valid,
    output logic [6:0] sseg_data,
    output logic [2:0] digit_sel,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(MSG_LEN - 1);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t state;
    logic [2:0] idx;
    logic sync1, btn_s;
    logic db, db_q;
    logic [CW-1:0] cnt;
    logic start;

    function automatic logic [6:0] glyph(input logic [2:0] i);
        case (i)
            3'd0:    glyph = 7'b0001001;
            3'd1:    glyph = 7'b1111001;
            default: glyph = BLANK;
        endcase
    endfunction

    function automatic logic [2:0] sel(input logic [2:0] i);
        sel = IDX_LAST - i;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= BTNC;
            btn_s <= sync1;
        end
    end

    // Any sample matching the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            db_q <= db;
            if (btn_s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                db  <= ~db;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign start = db & ~db_q;

`ifdef DISP_MSG_REPEAT_EN
    logic stop;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            valid     <= 1'b0;
            sseg_data <= BLANK;
            digit_sel <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DISP_MSG_REPEAT_EN
            stop      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SEND;
                        idx       <= 3'd0;
                        valid     <= 1'b1;
                        sseg_data <= glyph(3'd0);
                        digit_sel <= IDX_LAST;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
`ifdef DISP_MSG_REPEAT_EN
                    if (start) stop <= 1'b1;
`endif
                    // valid is always high here, so ready alone marks a transfer.
                    if (ready) begin
                        if (idx == IDX_LAST) begin
                            state     <= DONE;
                            valid     <= 1'b0;
                            sseg_data <= BLANK;
                            digit_sel <= 3'd0;
                            done      <= 1'b1;
                        end else begin
                            idx       <= idx + 3'd1;
                            sseg_data <= glyph(idx + 3'd1);
                            digit_sel <= sel(idx + 3'd1);
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
`ifdef DISP_MSG_REPEAT_EN
                    if (stop) begin
                        state <= IDLE;
                        stop  <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        if (start) stop <= 1'b1;
                        state     <= SEND;
                        idx       <= 3'd0;
                        valid     <= 1'b1;
                        sseg_data <= glyph(3'd0);
                        digit_sel <= IDX_LAST;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_msg_src.sv
// Directed plus random bench for disp_msg_src against a queue-based message model.
module tb_disp_msg_src;

    localparam int N = 4;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic BTNC = 1'b1;
    logic ready = 1'b1;
    logic valid, busy, done;
    logic [6:0] sseg_data;
    logic [2:0] digit_sel;

    disp_msg_src #(.DEBOUNCE_CYCLES(N), .MSG_LEN(L)) dut (
        .clk(clk), .rst(rst), .BTNC(BTNC), .ready(ready),
        .valid(valid), .sseg_data(sseg_data), .digit_sel(digit_sel),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int dut_xfers = 0;
    int dut_dones = 0;

    always @(posedge clk) begin
        if (!rst && valid && ready) dut_xfers <= dut_xfers + 1;
        if (!rst && done) dut_dones <= dut_dones + 1;
    end

    logic s_q[$];
    logic hist[$];
    logic m_db, m_dbq, m_done;
    int q[$];

    function automatic logic [6:0] glyph(input int i);
        if (i == 0) return 7'b0001001;
        if (i == 1) return 7'b1111001;
        return 7'b1111111;
    endfunction

    task automatic model_reset();
        s_q.delete();
        s_q.push_back(1'b0);
        s_q.push_back(1'b0);
        hist.delete();
        m_db = 1'b0;
        m_dbq = 1'b0;
        q.delete();
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        logic bs, st;
        int tmp;
        if (rst) begin
            model_reset();
            return;
        end
        st = m_db & ~m_dbq;
        bs = s_q.pop_front();
        s_q.push_back(BTNC);
        m_dbq = m_db;
        if (bs == m_db) hist.delete();
        else begin
            hist.push_back(bs);
            if (hist.size() == N) begin
                m_db = ~m_db;
                hist.delete();
            end
        end
        if (m_done) m_done = 1'b0;
        else if (q.size() > 0) begin
            if (ready) begin
                tmp = q.pop_front();
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (st) begin
            for (int i = 0; i < L; i++) q.push_back(i);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic ev;
        ev = q.size() > 0;
        chk("valid", 32'(valid), 32'(ev));
        chk("sseg", 32'(sseg_data), ev ? 32'(glyph(q[0])) : 32'h7F);
        chk("digit_sel", 32'(digit_sel), ev ? 32'(L - 1 - q[0]) : 32'd0);
        chk("busy", 32'(busy), 32'(ev || m_done));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic cyc(input logic b, input logic r);
        BTNC = b;
        ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_valid(input logic b, input logic r, input string tag);
        int k;
        k = 0;
        while (!valid && k < 30) begin
            cyc(b, r);
            k++;
        end
        chk(tag, 32'(valid), 32'd1);
    endtask

    task automatic idle_low(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bx, bd;
        logic b;
        int len;
        model_reset();
        @(negedge clk);
        check_all();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        chk("rst_sseg", 32'(sseg_data), 32'h7F);
        chk("rst_valid", 32'(valid), 32'd0);

        // Button held through reset release still yields one message.
        bx = dut_xfers; bd = dut_dones;
        rst = 1'b0;
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b1);
        chk("held_xfers", 32'(dut_xfers - bx), 32'd2);
        chk("held_dones", 32'(dut_dones - bd), 32'd1);
        idle_low(10);

        bx = dut_xfers; bd = dut_dones;
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
        chk("press_xfers", 32'(dut_xfers - bx), 32'd2);
        chk("press_dones", 32'(dut_dones - bd), 32'd1);
        idle_low(10);

        bx = dut_xfers;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        idle_low(12);
        chk("glitch_xfers", 32'(dut_xfers - bx), 32'd0);

        wait_valid(1'b1, 1'b0, "bp_wait");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_sseg", 32'(sseg_data), 32'b0001001);
            chk("bp_sel", 32'(digit_sel), 32'd1);
        end
        cyc(1'b1, 1'b1);
        chk("bp_i_sseg", 32'(sseg_data), 32'b1111001);
        chk("bp_i_sel", 32'(digit_sel), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        idle_low(10);

        bx = dut_xfers; bd = dut_dones;
        wait_valid(1'b1, 1'b0, "busy_wait");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
        chk("busy_xfers", 32'(dut_xfers - bx), 32'd2);
        chk("busy_dones", 32'(dut_dones - bd), 32'd1);
        idle_low(10);

        wait_valid(1'b1, 1'b0, "mid_wait");
        bd = dut_dones;
        #2 rst = 1'b1;
        #1 model_reset();
        chk("mid_valid", 32'(valid), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        rst = 1'b0;
        idle_low(6);
        chk("mid_nodone", 32'(dut_dones - bd), 32'd0);
        bx = dut_xfers; bd = dut_dones;
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
        chk("after_xfers", 32'(dut_xfers - bx), 32'd2);
        chk("after_dones", 32'(dut_dones - bd), 32'd1);
        idle_low(10);

        for (int s = 0; s < 160; s++) begin
            b = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            for (int j = 0; j < len; j++) begin
                cyc(b, $urandom_range(0, 9) < 7);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
